rr_arb8: RTL and testbench
==========================

Name: rr_arb8

Overview:
- Synchronous round-robin arbiter. Shares one resource among 8 requesters.
- Produces a registered one-hot grant and its 3-bit binary index, using the same index encoding as the team's 8:3 encoder (bit k -> 3'dk).
- Holds each grant until the owner releases it, drops its request, or exceeds a hold limit.
- Sits in front of any shared datapath unit (ALU, bus, memory port) in the lab designs.

Parameters:
- MAX_HOLD, 15: maximum number of consecutive cycles a grant may stay valid. Range 1..15. 0 disables the limit.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- en  input  1  arbiter enable
- req  input  8  request vector; bit k = requester k
- done  input  1  owner release strobe; sampled only while valid=1
- gnt  output  8  registered one-hot grant; all zeros when no grant
- gnt_idx  output  3  binary index of granted requester
- valid  output  1  high while a grant is held
- tout  output  1  one-cycle pulse on a forced (hold-limit) release

Behaviour:
- Reset (rst=1 at posedge), taking priority over all other inputs:
  - state=IDLE, gnt=8'h00, gnt_idx=3'd0, valid=0, tout=0.
  - Round-robin pointer ptr=3'd0, hold counter hcnt=0.
- State machine has two states: IDLE and BUSY.
- IDLE:
  - If en=1 and req!=0: winner = first set bit of req scanning ptr, ptr+1, ... 7, 0, ... ptr-1 (mod 8).
  - On that edge: gnt=one-hot(winner), gnt_idx=winner, valid=1, hcnt=1, state=BUSY.
  - Latency: req sampled at edge k; grant visible after edge k.
  - If en=0 or req=0: outputs stay cleared and state stays IDLE.
  - done is ignored in IDLE.
- BUSY: release condition at an edge is any of:
  - (a) done=1;
  - (b) req[gnt_idx]=0;
  - (c) en=0;
  - (d) MAX_HOLD!=0 and hcnt==MAX_HOLD.
- On release:
  - gnt=0, valid=0, gnt_idx holds its last value, ptr=gnt_idx+1 (wraps 7->0), hcnt=0, state=IDLE.
  - tout=1 for one cycle only if (d) is the sole cause; if (a), (b) or (c) coincide with (d), tout=0.
- Otherwise in BUSY: grant held unchanged, hcnt increments. hcnt saturates at 15 when MAX_HOLD=0.
- Requests from other requesters never preempt a held grant.
- At least one idle cycle (valid=0) always separates two grants. Back-to-back grants to different owners are impossible.
- Grant uniqueness: gnt is always zero or one-hot; never multi-hot.
- tout is 0 in every cycle except the one following a forced release.
- Reset in BUSY clears the grant at that edge; no tout pulse.
- A requester that re-asserts immediately after release is served again only after all other pending requesters ahead of it in round-robin order.

Test Plan:
- Reset: rst=1 for 2 cycles with req=8'hFF, en=1 -> gnt=00, valid=0, tout=0. After release of rst, first grant is gnt=01, gnt_idx=0.
- Fairness: req=8'hFF held, en=1, done pulsed 1 cycle after each grant -> grant order 0,1,2,...,7,0 on gnt_idx, with valid=0 for exactly one cycle between grants.
- Wrap and priority: ptr=6 (after a grant to 5), req=8'b0000_0101 -> gnt_idx=0, not 2. Next grant with the same req -> gnt_idx=2.
- Hold limit: MAX_HOLD=4, req=8'h08, done=0 -> valid high for exactly 4 cycles, then tout=1 for 1 cycle, gnt=00. Re-grant to 3 follows one cycle later.
- Request drop and enable: grant to 5, then req[5] deasserted -> release next edge, tout=0. Separately, en=0 during BUSY -> release next edge. en=0 with req=8'hFF -> no grant ever.
- Mid-grant reset: grant to 4 held 2 cycles, rst=1 -> all outputs cleared next edge. After rst deasserts with req=8'h10, first grant is to 4 (ptr reset to 0).

Source files
------------

// File: rtl/rr_arb8.sv
// rr_arb8 -- 8-way round-robin arbiter with a registered grant.
//
// A grant is held until the owner strobes done, drops its request, the
// arbiter is disabled, or the grant has been valid for MAX_HOLD cycles.
// After each release the round-robin pointer moves to the slot after the
// released owner. At least one idle cycle always separates two grants.
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous reset, active-high
//   en       arbiter enable
//   req      [7:0] request vector, bit k = requester k
//   done     owner release strobe (looked at only while a grant is held)
//   gnt      [7:0] registered one-hot grant, zero when idle
//   gnt_idx  [2:0] binary index of the granted requester (bit k -> 3'dk)
//   valid    high while a grant is held
//   tout     one-cycle pulse after a release caused only by the hold limit
module rr_arb8 #(
  parameter int MAX_HOLD = 15  // 1..15; 0 disables the hold limit
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       valid,
  output logic       tout
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  localparam logic [3:0] HOLD_LIM = 4'(MAX_HOLD);

  state_e     state_q, state_d;
  logic [7:0] gnt_q, gnt_d;
  logic [2:0] idx_q, idx_d;
  logic [2:0] ptr_q, ptr_d;
  logic [3:0] hcnt_q, hcnt_d;
  logic       tout_q, tout_d;

  // Winner search: first set request starting at ptr and wrapping.
  logic [2:0] win_idx;
  logic       win_vld;

  always_comb begin
    win_idx = 3'd0;
    win_vld = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (!win_vld && req[3'(ptr_q + 3'(i))]) begin
        win_idx = 3'(ptr_q + 3'(i));
        win_vld = 1'b1;
      end
    end
  end

  // Release causes while BUSY. The "soft" causes suppress tout.
  logic soft_rel, limit_hit;
  assign soft_rel  = done | ~req[idx_q] | ~en;
  assign limit_hit = (HOLD_LIM != 4'd0) && (hcnt_q == HOLD_LIM);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    hcnt_d  = hcnt_q;
    tout_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (en && win_vld) begin
          gnt_d   = 8'h01 << win_idx;
          idx_d   = win_idx;
          hcnt_d  = 4'd1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (soft_rel || limit_hit) begin
          gnt_d   = 8'h00;
          ptr_d   = idx_q + 3'd1;  // wraps 7 -> 0
          hcnt_d  = 4'd0;
          tout_d  = limit_hit & ~soft_rel;
          state_d = IDLE;
        end else if (hcnt_q != 4'd15) begin
          hcnt_d = hcnt_q + 4'd1;  // saturates when the limit is disabled
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= 8'h00;
      idx_q   <= 3'd0;
      ptr_q   <= 3'd0;
      hcnt_q  <= 4'd0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      hcnt_q  <= hcnt_d;
      tout_q  <= tout_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_idx = idx_q;
  assign valid   = (state_q == BUSY);
  assign tout    = tout_q;

endmodule

// File: tb/tb_rr_arb8.sv
module tb_rr_arb8;

  logic       clk = 1'b0;
  logic       rst, en, done;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       valid, tout;

  always #5 clk = ~clk;

  rr_arb8 #(.MAX_HOLD(4)) dut (
    .clk(clk), .rst(rst), .en(en), .req(req), .done(done),
    .gnt(gnt), .gnt_idx(gnt_idx), .valid(valid), .tout(tout)
  );

  // One record = inputs held across one rising edge + outputs expected after it.
  typedef struct {
    logic       rst;
    logic       en;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       v;
    logic       t;
  } vec_t;

  vec_t vq[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic add(input logic r, input logic e, input logic [7:0] rq,
                     input logic d, input logic [7:0] g, input logic [2:0] ix,
                     input logic v, input logic t);
    vec_t x;
    x.rst = r; x.en = e; x.req = rq; x.done = d;
    x.gnt = g; x.idx = ix; x.v = v; x.t = t;
    vq.push_back(x);
  endtask

  task automatic check(input string name, input vec_t x);
    n_vec++;
    if (gnt !== x.gnt || gnt_idx !== x.idx || valid !== x.v || tout !== x.t) begin
      n_err++;
      $display("FAIL %s: got gnt=%h idx=%0d valid=%b tout=%b, want gnt=%h idx=%0d valid=%b tout=%b",
               name, gnt, gnt_idx, valid, tout, x.gnt, x.idx, x.v, x.t);
    end
    // Structural invariant: gnt zero or one-hot, and nonzero exactly when valid.
    n_vec++;
    if (!$onehot0(gnt) || ((gnt != 8'h00) !== valid)) begin
      n_err++;
      $display("FAIL %s_onehot: got gnt=%h valid=%b, want one-hot-or-zero gnt matching valid",
               name, gnt, valid);
    end
  endtask

  task automatic apply(input string name, input vec_t x);
    rst = x.rst; en = x.en; req = x.req; done = x.done;
    @(posedge clk);
    #1;
    check(name, x);
  endtask

  initial begin
    logic [2:0] k3;
    rst = 1'b1; en = 1'b1; req = 8'hFF; done = 1'b0;

    // Reset with everything requesting, then first grant goes to 0.
    add(1, 1, 8'hFF, 0, 8'h00, 3'd0, 0, 0);
    add(1, 1, 8'hFF, 0, 8'h00, 3'd0, 0, 0);
    add(0, 1, 8'hFF, 0, 8'h01, 3'd0, 1, 0);

    // Fairness: done one cycle after each grant -> 1..7 then 0, one idle cycle between.
    for (int k = 1; k <= 8; k++) begin
      k3 = 3'(k);
      add(0, 1, 8'hFF, 1, 8'h00, 3'(k - 1), 0, 0);
      add(0, 1, 8'hFF, 0, 8'h01 << k3, k3, 1, 0);
    end
    add(0, 1, 8'hFF, 1, 8'h00, 3'd0, 0, 0);        // release 0, ptr=1

    // Wrap and priority: grant 5 -> ptr=6, then req 0 and 2 -> 0 first, then 2.
    add(0, 1, 8'h20, 0, 8'h20, 3'd5, 1, 0);
    add(0, 1, 8'h20, 1, 8'h00, 3'd5, 0, 0);
    add(0, 1, 8'h05, 0, 8'h01, 3'd0, 1, 0);
    add(0, 1, 8'h05, 1, 8'h00, 3'd0, 0, 0);
    add(0, 1, 8'h05, 0, 8'h04, 3'd2, 1, 0);
    add(0, 1, 8'h05, 1, 8'h00, 3'd2, 0, 0);        // ptr=3

    // Hold limit (MAX_HOLD=4): valid for 4 cycles, tout pulse, re-grant next cycle.
    add(0, 1, 8'h08, 0, 8'h08, 3'd3, 1, 0);
    add(0, 1, 8'h08, 0, 8'h08, 3'd3, 1, 0);
    add(0, 1, 8'h08, 0, 8'h08, 3'd3, 1, 0);
    add(0, 1, 8'h08, 0, 8'h08, 3'd3, 1, 0);
    add(0, 1, 8'h08, 0, 8'h00, 3'd3, 0, 1);
    add(0, 1, 8'h08, 0, 8'h08, 3'd3, 1, 0);
    add(0, 1, 8'h00, 0, 8'h00, 3'd3, 0, 0);        // request drop, ptr=4

    // Request drop on a grant to 5.
    add(0, 1, 8'h20, 0, 8'h20, 3'd5, 1, 0);
    add(0, 1, 8'h00, 0, 8'h00, 3'd5, 0, 0);        // ptr=6

    // en=0 while busy releases; en=0 never grants.
    add(0, 1, 8'hFF, 0, 8'h40, 3'd6, 1, 0);
    add(0, 0, 8'hFF, 0, 8'h00, 3'd6, 0, 0);        // ptr=7
    for (int k = 0; k < 5; k++)
      add(0, 0, 8'hFF, 0, 8'h00, 3'd6, 0, 0);

    // done coinciding with the hold limit: release without tout.
    add(0, 1, 8'hFF, 0, 8'h80, 3'd7, 1, 0);
    add(0, 1, 8'hFF, 0, 8'h80, 3'd7, 1, 0);
    add(0, 1, 8'hFF, 0, 8'h80, 3'd7, 1, 0);
    add(0, 1, 8'hFF, 0, 8'h80, 3'd7, 1, 0);
    add(0, 1, 8'hFF, 1, 8'h00, 3'd7, 0, 0);        // ptr=0

    // done in IDLE is ignored: a grant still happens.
    add(0, 1, 8'h02, 1, 8'h02, 3'd1, 1, 0);
    add(0, 1, 8'h02, 1, 8'h00, 3'd1, 0, 0);        // ptr=2

    // Mid-grant reset: grant 4 held 2 cycles, then reset clears everything.
    add(0, 1, 8'h10, 0, 8'h10, 3'd4, 1, 0);
    add(0, 1, 8'h10, 0, 8'h10, 3'd4, 1, 0);
    add(1, 1, 8'h10, 0, 8'h00, 3'd0, 0, 0);
    add(0, 1, 8'h10, 0, 8'h10, 3'd4, 1, 0);
    add(0, 1, 8'h10, 1, 8'h00, 3'd4, 0, 0);        // ptr=5
    // Reset must bring ptr back to 0: req {0,4} then grants 0, not 4.
    add(1, 1, 8'h11, 0, 8'h00, 3'd0, 0, 0);
    add(0, 1, 8'h11, 0, 8'h01, 3'd0, 1, 0);

    foreach (vq[i]) apply($sformatf("vec%0d", i), vq[i]);

    // Hand sequence: re-requester waits behind others in rr order.
    // ptr=1 after releasing 0; requesters 0 and 6 pending -> 6 before 0.
    begin
      vec_t x;
      x.rst = 0; x.en = 1; x.req = 8'h41; x.done = 1;
      x.gnt = 8'h00; x.idx = 3'd0; x.v = 0; x.t = 0;
      apply("rr_rel0", x);
      x.done = 0; x.gnt = 8'h40; x.idx = 3'd6; x.v = 1;
      apply("rr_grant6", x);
      x.done = 1; x.gnt = 8'h00; x.v = 0;
      apply("rr_rel6", x);
      x.done = 0; x.gnt = 8'h01; x.idx = 3'd0; x.v = 1;
      apply("rr_grant0", x);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
